// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 frame receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, RECV, CHECK, NEW} state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // start + data + optional parity + stop
   function automatic int frame_bits(input int data_bits, input int parity_mode);
      return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + 1;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronisers for kbd_clk/kbd_dat plus kbd_clk falling-edge detect.
// Define PS2_RX_GLITCH_FILTER_EN to insert a FILTER_LEN-sample glitch filter on kbd_clk.
module ps2_line_sync #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic resetN,
   input  logic kbd_clk,
   input  logic kbd_dat,
   output logic dat_s,
   output logic fall_det
);

   if (FILTER_LEN < 1) begin : g_bad_filter_len
      $error("ps2_line_sync: FILTER_LEN must be >= 1");
   end

   logic [1:0] clk_ff, dat_ff;
   logic       clk_line, clk_prev;

   // Lines idle high, so reset to 1 keeps a spurious edge out of the first cycles.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         clk_ff <= 2'b11;
         dat_ff <= 2'b11;
      end else begin
         clk_ff <= {clk_ff[0], kbd_clk};
         dat_ff <= {dat_ff[0], kbd_dat};
      end
   end

`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FCW = $clog2(FILTER_LEN + 1);
   logic [FCW-1:0] flt_cnt;
   logic           flt_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         flt_cnt <= '0;
         flt_q   <= 1'b1;
      end else if (clk_ff[1] == flt_q) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
         flt_q   <= clk_ff[1];
         flt_cnt <= '0;
      end else begin
         flt_cnt <= flt_cnt + 1'b1;
      end
   end

   assign clk_line = flt_q;
`else
   assign clk_line = clk_ff[1];
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) clk_prev <= 1'b1;
      else         clk_prev <= clk_line;
   end

   assign fall_det = clk_prev & ~clk_line;
   assign dat_s    = dat_ff[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// Parametrised PS/2 frame receiver: start, DATA_BITS LSB-first, optional parity, stop.
// PS2_RX_GLITCH_FILTER_EN (in ps2_line_sync) adds a glitch filter on kbd_clk.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 1,
   parameter int TIMEOUT_CYC = 50000,
   parameter int FILTER_LEN  = 8
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 kbd_clk,
   input  logic                 kbd_dat,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_new,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE);
   localparam int SH_W       = FRAME_BITS - 1;
   localparam int BC_W       = $clog2(FRAME_BITS + 1);
   localparam int TO_W       = $clog2(TIMEOUT_CYC);

   if (DATA_BITS < 1 || DATA_BITS > 16 || PARITY_MODE < 0 || PARITY_MODE > 2 || TIMEOUT_CYC < 4)
   begin : g_bad_param
      $error("ps2_frame_rx: parameter out of range");
   end

   logic dat_s, fall_det;

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
      .clk      (clk),
      .resetN   (resetN),
      .kbd_clk  (kbd_clk),
      .kbd_dat  (kbd_dat),
      .dat_s    (dat_s),
      .fall_det (fall_det)
   );

   state_t                state, state_nxt;
   logic [BC_W-1:0]       bit_cnt, bit_cnt_nxt;
   logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
   logic [SH_W-1:0]       sh, sh_nxt;
   logic [DATA_BITS-1:0]  dout_nxt, data;
   logic                  new_nxt, perr_nxt, ferr_nxt, terr_nxt;
   logic                  par_bit, stop_bit, par_ok;

   // Bits enter at the MSB, so after the stop bit the data sits LSB-aligned.
   assign data     = sh[DATA_BITS-1:0];
   assign par_bit  = sh[DATA_BITS];
   assign stop_bit = sh[SH_W-1];

   always_comb begin
      par_ok = 1'b1;
      if (PARITY_MODE == PAR_ODD)       par_ok = ^{data, par_bit};
      else if (PARITY_MODE == PAR_EVEN) par_ok = ~^{data, par_bit};
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      to_cnt_nxt  = to_cnt;
      sh_nxt      = sh;
      dout_nxt    = dout;
      new_nxt     = 1'b0;
      perr_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      terr_nxt    = 1'b0;
      case (state)
         IDLE: begin
            to_cnt_nxt = '0;
            if (fall_det && !dat_s) begin
               state_nxt   = RECV;
               bit_cnt_nxt = BC_W'(1);
            end
         end
         RECV: begin
            // A falling edge always beats an expiring timeout.
            if (fall_det) begin
               sh_nxt     = {dat_s, sh[SH_W-1:1]};
               to_cnt_nxt = '0;
               if (bit_cnt == BC_W'(FRAME_BITS - 1)) begin
                  state_nxt   = CHECK;
                  bit_cnt_nxt = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 2)) begin
               // The count would reach TIMEOUT_CYC-1 on this edge: abort instead.
               state_nxt   = IDLE;
               terr_nxt    = 1'b1;
               to_cnt_nxt  = '0;
               bit_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         CHECK: begin
            if (par_ok && stop_bit) begin
               dout_nxt  = data;
               new_nxt   = 1'b1;
               state_nxt = NEW;
            end else begin
               perr_nxt  = ~par_ok;
               ferr_nxt  = ~stop_bit;
               state_nxt = IDLE;
            end
         end
         NEW:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         to_cnt      <= '0;
         sh          <= '0;
         dout        <= '0;
         dout_new    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         to_cnt      <= to_cnt_nxt;
         sh          <= sh_nxt;
         dout        <= dout_nxt;
         dout_new    <= new_nxt;
         parity_err  <= perr_nxt;
         frame_err   <= ferr_nxt;
         timeout_err <= terr_nxt;
      end
   end

   assign busy = (state == RECV) || (state == CHECK);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised self-checking bench for ps2_frame_rx against a frame-level reference model.
module tb_ps2_frame_rx;

   localparam int T = 100;
`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FLAT = 4;
`else
   localparam int FLAT = 0;
`endif

   logic clk = 1'b0, resetN = 1'b0;
   logic kc0 = 1'b1, kd0 = 1'b1, kc1 = 1'b1, kd1 = 1'b1, kc2 = 1'b1, kd2 = 1'b1;
   logic [7:0] dout0, dout2;
   logic [8:0] dout1;
   logic [2:0] dnew, perr, ferr, terr, busy;
   logic [15:0] dw [3];

   // inst 0: 8 bits odd parity; inst 1: 9 bits no parity; inst 2: 8 bits even parity
   ps2_frame_rx #(.DATA_BITS(8), .PARITY_MODE(1), .TIMEOUT_CYC(T), .FILTER_LEN(4)) u0 (
      .clk(clk), .resetN(resetN), .kbd_clk(kc0), .kbd_dat(kd0), .dout(dout0),
      .dout_new(dnew[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
      .timeout_err(terr[0]), .busy(busy[0]));
   ps2_frame_rx #(.DATA_BITS(9), .PARITY_MODE(0), .TIMEOUT_CYC(T), .FILTER_LEN(4)) u1 (
      .clk(clk), .resetN(resetN), .kbd_clk(kc1), .kbd_dat(kd1), .dout(dout1),
      .dout_new(dnew[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
      .timeout_err(terr[1]), .busy(busy[1]));
   ps2_frame_rx #(.DATA_BITS(8), .PARITY_MODE(2), .TIMEOUT_CYC(T), .FILTER_LEN(4)) u2 (
      .clk(clk), .resetN(resetN), .kbd_clk(kc2), .kbd_dat(kd2), .dout(dout2),
      .dout_new(dnew[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
      .timeout_err(terr[2]), .busy(busy[2]));

   assign dw[0] = {8'h00, dout0};
   assign dw[1] = {7'h00, dout1};
   assign dw[2] = {8'h00, dout2};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int vectors = 0, miscompares = 0;
   int n_new [3], n_perr [3], n_ferr [3], n_to [3];
   int c_new [3], c_err [3], c_to [3], busy_cnt [3], busy_last [3];
   logic [15:0] snap [3];
   logic [15:0] model_dout [3];
   int nd_of [3] = '{8, 9, 8};
   int mode_of [3] = '{1, 0, 2};

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (dnew[i]) begin
            if (n_new[i] == 0) c_new[i] = cyc;
            n_new[i]++;
            snap[i] = dw[i];
         end
         if ((perr[i] || ferr[i]) && c_err[i] < 0) c_err[i] = cyc;
         if (perr[i]) n_perr[i]++;
         if (ferr[i]) n_ferr[i]++;
         if (terr[i]) begin
            if (n_to[i] == 0) c_to[i] = cyc;
            n_to[i]++;
         end
         if (busy[i]) begin
            busy_cnt[i]++;
            busy_last[i] = cyc;
         end
      end
   end

   task automatic clr_mon();
      for (int i = 0; i < 3; i++) begin
         n_new[i] = 0; n_perr[i] = 0; n_ferr[i] = 0; n_to[i] = 0;
         c_new[i] = -1; c_err[i] = -1; c_to[i] = -1;
         busy_cnt[i] = 0; busy_last[i] = -1;
      end
   endtask

   task automatic set_line(input int i, input logic c, input logic d);
      case (i)
         0: begin kc0 = c; kd0 = d; end
         1: begin kc1 = c; kd1 = d; end
         default: begin kc2 = c; kd2 = d; end
      endcase
   endtask

   // Each bit: data set while clock high, 6 cycles high, 6 cycles low.
   task automatic send_bits(input int i, input logic [31:0] bits, input int nb, output int last_n);
      last_n = -1;
      for (int b = 0; b < nb; b++) begin
         @(posedge clk); #1 set_line(i, 1'b1, bits[b]);
         repeat (6) @(posedge clk);
         #1 set_line(i, 1'b0, bits[b]);
         last_n = cyc;
         repeat (6) @(posedge clk);
         #1 set_line(i, 1'b1, bits[b]);
      end
   endtask

   function automatic int frame_len(input int nd, input int mode);
      return nd + ((mode != 0) ? 3 : 2);
   endfunction

   function automatic logic [31:0] mk_frame(input logic [15:0] d, input int nd, input int mode,
                                            input logic par, input logic stop);
      logic [31:0] f = '0;
      int p;
      for (int k = 0; k < nd; k++) f[1+k] = d[k];
      p = 1 + nd;
      if (mode != 0) begin f[p] = par; p++; end
      f[p] = stop;
      return f;
   endfunction

   function automatic logic good_par(input logic [15:0] d, input int mode);
      int ones = $countones(d);
      return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   function automatic logic par_passes(input logic [15:0] d, input int mode, input logic par);
      int tot = $countones(d) + int'(par);
      if (mode == 0) return 1'b1;
      return (mode == 1) ? ((tot % 2) == 1) : ((tot % 2) == 0);
   endfunction

   task automatic run_frame(input int i, input logic [15:0] d, input logic par, input logic stop,
                            input string tag);
      int n;
      logic ok_p, good;
      clr_mon();
      send_bits(i, mk_frame(d, nd_of[i], mode_of[i], par, stop), frame_len(nd_of[i], mode_of[i]), n);
      repeat (12 + FLAT) @(posedge clk);
      #1;
      ok_p = par_passes(d, mode_of[i], par);
      good = ok_p && stop;
      if (good) model_dout[i] = d;
      vectors++;
      if (n_new[i] !== int'(good)) begin miscompares++;
         $display("FAIL %s dout_new count: got %0d expected %0d", tag, n_new[i], int'(good)); end
      vectors++;
      if (n_perr[i] !== int'(!ok_p)) begin miscompares++;
         $display("FAIL %s parity_err count: got %0d expected %0d", tag, n_perr[i], int'(!ok_p)); end
      vectors++;
      if (n_ferr[i] !== int'(!stop)) begin miscompares++;
         $display("FAIL %s frame_err count: got %0d expected %0d", tag, n_ferr[i], int'(!stop)); end
      vectors++;
      if (n_to[i] !== 0) begin miscompares++;
         $display("FAIL %s timeout_err count: got %0d expected 0", tag, n_to[i]); end
      vectors++;
      if (good) begin
         if (c_new[i] !== n + 4 + FLAT || snap[i] !== d) begin miscompares++;
            $display("FAIL %s dout_new timing/data: got cyc %0d dout %0h expected cyc %0d dout %0h",
                     tag, c_new[i], snap[i], n + 4 + FLAT, d); end
      end else begin
         if (c_err[i] !== n + 4 + FLAT) begin miscompares++;
            $display("FAIL %s error strobe cycle: got %0d expected %0d", tag, c_err[i], n + 4 + FLAT); end
      end
      vectors++;
      if (dw[i] !== model_dout[i]) begin miscompares++;
         $display("FAIL %s dout held: got %0h expected %0h", tag, dw[i], model_dout[i]); end
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      for (int i = 0; i < 3; i++) model_dout[i] = '0;
      resetN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {dout0, dout1, dout2, dnew, perr, ferr};
      vectors++;
      if (obs !== '0) begin miscompares++;
         $display("FAIL reset data/strobes: got %0h expected 0", obs); end
      vectors++;
      if ({terr, busy} !== 6'b0) begin miscompares++;
         $display("FAIL reset timeout/busy: got %0b expected 0", {terr, busy}); end
      @(negedge clk) resetN = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_plan_frames();
      run_frame(0, 16'h1C, 1'b0, 1'b1, "good_1C");
      run_frame(0, 16'h1C, 1'b1, 1'b1, "parerr_1C");
      run_frame(0, 16'hF0, 1'b1, 1'b0, "stoperr_F0");
      run_frame(0, 16'hF0, 1'b1, 1'b1, "good_F0");
   endtask

   task automatic test_timeout();
      int n;
      clr_mon();
      send_bits(0, mk_frame(16'h5A, 8, 1, 1'b1, 1'b1), 5, n);
      repeat (T + 20) @(posedge clk);
      #1;
      vectors++;
      if (n_to[0] !== 1 || c_to[0] !== n + 2 + FLAT + T) begin miscompares++;
         $display("FAIL timeout strobe: got count %0d cyc %0d expected 1 cyc %0d",
                  n_to[0], c_to[0], n + 2 + FLAT + T); end
      vectors++;
      if (busy_last[0] !== n + 1 + FLAT + T) begin miscompares++;
         $display("FAIL timeout busy drop: last busy cyc %0d expected %0d", busy_last[0], n + 1 + FLAT + T); end
      vectors++;
      if (n_new[0] !== 0 || dw[0] !== model_dout[0]) begin miscompares++;
         $display("FAIL timeout no data: got new %0d dout %0h expected 0 %0h", n_new[0], dw[0], model_dout[0]); end
      run_frame(0, 16'h5A, 1'b1, 1'b1, "after_timeout_5A");
   endtask

   task automatic test_wide();
      run_frame(1, 16'h1A5, 1'b0, 1'b1, "nopar_1A5");
      run_frame(2, 16'h03, 1'b0, 1'b1, "even_03");
      run_frame(2, 16'h03, 1'b1, 1'b1, "even_03_bad");
   endtask

   task automatic test_back_to_back();
      int n;
      logic [15:0] d [3] = '{16'h11, 16'hA7, 16'h3C};
      clr_mon();
      for (int k = 0; k < 3; k++)
         send_bits(0, mk_frame(d[k], 8, 1, good_par(d[k], 1), 1'b1), 11, n);
      repeat (12 + FLAT) @(posedge clk);
      #1;
      model_dout[0] = d[2];
      vectors++;
      if (n_new[0] !== 3 || snap[0] !== d[2] || dw[0] !== d[2]) begin miscompares++;
         $display("FAIL back_to_back: got %0d frames last %0h expected 3 last %0h", n_new[0], snap[0], d[2]); end
   endtask

   task automatic test_glitch();
      int exp_to = (FLAT > 0) ? 0 : 1;
      int exp_busy = (FLAT > 0) ? 0 : 1;
      clr_mon();
      @(posedge clk); #1 set_line(0, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1 set_line(0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 set_line(0, 1'b1, 1'b0);
      repeat (T + 20) @(posedge clk);
      #1 set_line(0, 1'b1, 1'b1);
      vectors++;
      if (int'(busy_cnt[0] > 0) !== exp_busy) begin miscompares++;
         $display("FAIL glitch busy: got %0d busy cycles expected busy seen=%0d", busy_cnt[0], exp_busy); end
      vectors++;
      if (n_to[0] !== exp_to) begin miscompares++;
         $display("FAIL glitch timeout: got %0d expected %0d", n_to[0], exp_to); end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset_midframe();
      int n;
      clr_mon();
      send_bits(0, mk_frame(16'hE1, 8, 1, 1'b1, 1'b1), 4, n);
      #1;
      vectors++;
      if (busy[0] !== 1'b1) begin miscompares++;
         $display("FAIL midframe busy before reset: got %0b expected 1", busy[0]); end
      resetN = 1'b0;
      for (int i = 0; i < 3; i++) model_dout[i] = '0;
      #1;
      vectors++;
      if (busy[0] !== 1'b0 || dw[0] !== model_dout[0]) begin miscompares++;
         $display("FAIL midframe reset: got busy %0b dout %0h expected 0 0", busy[0], dw[0]); end
      @(negedge clk) resetN = 1'b1;
      repeat (4) @(posedge clk);
      run_frame(0, 16'h33, good_par(16'h33, 1), 1'b1, "after_reset_33");
   endtask

   task automatic test_random();
      for (int k = 0; k < 24; k++) begin
         int i = k % 3;
         logic [15:0] d = 16'($urandom) & 16'((1 << nd_of[i]) - 1);
         logic par = good_par(d, mode_of[i]) ^ ($urandom_range(0, 3) == 0);
         logic stop = ($urandom_range(0, 3) != 0);
         run_frame(i, d, par, stop, "random");
      end
   endtask

   initial begin
      test_reset();
      test_plan_frames();
      test_timeout();
      test_wide();
      test_back_to_back();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
